// File: rtl/way_alloc_ctrl.sv
// Purpose : entry allocator for a small fully-associative structure: picks a fill
//           victim (lowest invalid entry, else tree-PLRU), tracks valid bits and count.
// Latency : victim selection and grant are combinational from registered state;
//           valid/count/PLRU updates land on the next clk_i edge.
// Backpressure: one allocation outstanding at a time; alloc_req_i is not granted
//           while busy (PEND), during FLUSH, while flush_i is high or during reset.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   flush_i             invalidate everything and clear replacement state
//   hit_i               one-hot lookup hit, marks an entry most recently used
//   inval_i             per-entry invalidate
//   alloc_req_i         request for an entry to fill
//   alloc_gnt_o         request granted this cycle
//   alloc_idx_o         chosen entry (meaningful with alloc_gnt_o)
//   alloc_evict_o       chosen entry currently holds valid data
//   fill_done_i         requester finished filling the granted entry
//   valid_o, count_o    per-entry valid bits and their population count
//   full_o, busy_o      all entries valid / allocation outstanding
module way_alloc_ctrl #(
    parameter int ENTRIES = 8,
    localparam int IDX_W = $clog2(ENTRIES)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic [ENTRIES-1:0] hit_i,
    input  logic [ENTRIES-1:0] inval_i,
    input  logic               alloc_req_i,
    output logic               alloc_gnt_o,
    output logic [IDX_W-1:0]   alloc_idx_o,
    output logic               alloc_evict_o,
    input  logic               fill_done_i,
    output logic [ENTRIES-1:0] valid_o,
    output logic [IDX_W:0]     count_o,
    output logic               full_o,
    output logic               busy_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PEND  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // Tree layout: node 0 is the root, node k has children 2k+1 / 2k+2,
    // leaves are entries 0..ENTRIES-1 left to right. Bit = 1 points right.
    logic [1:0]         state_q, state_d;
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-2:0] plru_q,  plru_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [IDX_W:0]     count_q, count_d;

    logic [IDX_W-1:0]   victim_idx;
    logic               victim_evict;
    logic [ENTRIES-1:0] hit_eff;
    logic               hit_vld;
    logic [IDX_W-1:0]   hit_idx;
    logic               gnt;

    // Walk from the root along idx's bits (MSB first) and make every node on
    // the path point to the opposite subtree.
    function automatic logic [ENTRIES-2:0] plru_touch(
        input logic [ENTRIES-2:0] tree,
        input logic [IDX_W-1:0]   idx
    );
        logic [ENTRIES-2:0] t;
        logic [IDX_W-1:0]   path;
        logic [IDX_W-1:0]   nd;
        logic               dir;
        t    = tree;
        path = idx;
        nd   = '0;
        for (int d = 0; d < IDX_W; d++) begin
            dir   = path[IDX_W-1];
            t[nd] = ~dir;
            // Final iteration computes a leaf position that is never used.
            nd    = (nd << 1) + IDX_W'(1) + IDX_W'(dir);
            path  = path << 1;
        end
        return t;
    endfunction

    // Follow node bits from the root; the directions taken spell the leaf index.
    function automatic logic [IDX_W-1:0] plru_victim(input logic [ENTRIES-2:0] tree);
        logic [IDX_W-1:0] v;
        logic [IDX_W-1:0] nd;
        logic             dir;
        v  = '0;
        nd = '0;
        for (int d = 0; d < IDX_W; d++) begin
            dir = tree[nd];
            v   = (v << 1) | IDX_W'(dir);
            nd  = (nd << 1) + IDX_W'(1) + IDX_W'(dir);
        end
        return v;
    endfunction

    function automatic logic [IDX_W-1:0] onehot_enc(input logic [ENTRIES-1:0] oh);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (oh[i]) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [IDX_W:0] popcount(input logic [ENTRIES-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            c = c + (IDX_W+1)'(v[i]);
        end
        return c;
    endfunction

    // Victim: lowest-index invalid entry wins over PLRU. Scanning downward
    // leaves the lowest invalid index as the last assignment.
    always_comb begin
        victim_idx   = plru_victim(plru_q);
        victim_evict = 1'b1;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                victim_idx   = IDX_W'(i);
                victim_evict = 1'b0;
            end
        end
    end

    // A hit only counts as a use if the entry is valid and not being
    // invalidated in the same cycle.
    assign hit_eff = hit_i & valid_q & ~inval_i;
    assign hit_vld = |hit_eff;
    assign hit_idx = onehot_enc(hit_eff);

    // rst_i gates the grant so nothing is handed out while reset is asserted.
    assign gnt = (state_q == ST_IDLE) && alloc_req_i && !flush_i && !rst_i;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q & ~inval_i;
        plru_d  = plru_q;
        idx_d   = idx_q;

        // Hit touch goes first so a same-cycle grant overrides shared nodes.
        if (state_q != ST_FLUSH && hit_vld) begin
            plru_d = plru_touch(plru_d, hit_idx);
        end

        case (state_q)
            ST_IDLE: begin
                if (gnt) begin
                    valid_d[victim_idx] = 1'b0;
                    idx_d               = victim_idx;
                    plru_d              = plru_touch(plru_d, victim_idx);
                    state_d             = ST_PEND;
                end
            end
            ST_PEND: begin
                // Validation of the pending entry overrides any invalidate of it;
                // a concurrent flush abandons it instead.
                if (fill_done_i && !flush_i) begin
                    valid_d[idx_q] = 1'b1;
                    state_d        = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                valid_d = '0;
                plru_d  = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush_i) begin
            state_d = ST_FLUSH;
        end

        count_d = popcount(valid_d);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            valid_q <= '0;
            plru_q  <= '0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            plru_q  <= plru_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    assign alloc_gnt_o   = gnt;
    assign alloc_idx_o   = victim_idx;
    assign alloc_evict_o = victim_evict;
    assign valid_o       = valid_q;
    assign count_o       = count_q;
    assign full_o        = (count_q == (IDX_W+1)'(ENTRIES));
    assign busy_o        = (state_q == ST_PEND);

endmodule

// File: doc/way_alloc_ctrl.md
WAY_ALLOC_CTRL -- requirements
Module: way_alloc_ctrl

Interface
REQ-001 SHALL have parameter ENTRIES, default 8, number of managed entries; power of two, >= 2.
REQ-002 SHALL have localparam IDX_W = $clog2(ENTRIES).
REQ-003 clk_i  input  1  clock; all state rises on posedge.
REQ-004 rst_i  input  1  reset; asynchronous and active-high.
REQ-005 flush_i  input  1  invalidate all entries and clear replacement state.
REQ-006 hit_i  input  ENTRIES  one-hot (or zero) lookup hit; marks entry most recently used.
REQ-007 inval_i  input  ENTRIES  per-entry invalidate, any number of bits.
REQ-008 alloc_req_i  input  1  requester asks for an entry to fill.
REQ-009 alloc_gnt_o  output  1  allocation accepted this cycle.
REQ-010 alloc_idx_o  output  IDX_W  chosen entry index, valid when alloc_gnt_o.
REQ-011 alloc_evict_o  output  1  chosen entry currently valid (eviction), valid when alloc_gnt_o.
REQ-012 fill_done_i  input  1  requester finished filling the granted entry.
REQ-013 valid_o  output  ENTRIES  per-entry valid bits.
REQ-014 count_o  output  IDX_W+1  number of valid entries.
REQ-015 full_o  output  1  count_o == ENTRIES.
REQ-016 busy_o  output  1  allocation outstanding (state PEND).

Function
REQ-017 SHALL hold tree-PLRU state of ENTRIES-1 node bits: node 0 is root, node k has children 2k+1, 2k+2; leaves map to entries 0..ENTRIES-1 left to right.
REQ-018 Touching entry i SHALL set every node on i's root-to-leaf path to point away from i (1 = right subtree, 0 = left).
REQ-019 PLRU victim SHALL be the leaf reached from root by following node bits (0 left, 1 right).
REQ-020 Victim selection SHALL be: lowest-index invalid entry if any exists, else PLRU victim; purely combinational from registered state.
REQ-021 FSM states: IDLE, PEND, FLUSH.
REQ-022 IDLE: alloc_gnt_o = alloc_req_i && !flush_i (combinational); on grant, chosen entry's valid bit cleared, index latched, PLRU touched with that index, go PEND.
REQ-023 PEND: alloc_gnt_o = 0; on fill_done_i, latched entry set valid, go IDLE; fill_done_i in IDLE/FLUSH ignored.
REQ-024 flush_i in any state SHALL go FLUSH next cycle; pending entry is abandoned (not validated).
REQ-025 FLUSH: lasts exactly one cycle; clears all valid bits and PLRU nodes to 0; alloc_gnt_o = 0; returns to IDLE (or stays FLUSH if flush_i still high).
REQ-026 hit_i SHALL touch PLRU only for a hit on a valid entry not simultaneously invalidated; in any state except FLUSH.
REQ-027 Hit and grant in the same cycle: hit touch applied first, grant touch applied last (grant wins at shared nodes).
REQ-028 inval_i clears valid bits next cycle; PLRU not changed; invalidate of the latched pending entry during PEND has no effect on its later validation.
REQ-029 count_o SHALL be registered, updated each cycle to equal popcount of next-state valid bits; never exceeds ENTRIES, never wraps.
REQ-030 alloc_idx_o/alloc_evict_o SHALL reflect the selection every cycle in IDLE; don't-care otherwise but must be X-free.

Reset
REQ-031 rst_i high SHALL asynchronously force: state IDLE, valid_o = 0, PLRU nodes = 0, count_o = 0, full_o = 0, busy_o = 0, latched index = 0.
REQ-032 Reset mid-PEND SHALL abandon the allocation; the entry stays invalid after reset release.
REQ-033 alloc_gnt_o SHALL be 0 while rst_i is high.

Verification (ENTRIES = 4)
REQ-034 After reset, four req/grant/fill_done cycles -> alloc_idx_o 0,1,2,3, alloc_evict_o 0 each; count_o 4, full_o 1.
REQ-035 Continue: next request -> alloc_idx_o 0, alloc_evict_o 1; instead hit_i=0001 first -> next grant alloc_idx_o 2.
REQ-036 Full, inval_i=0100 -> count_o 3 next cycle; next grant alloc_idx_o 2, alloc_evict_o 0.
REQ-037 Grant idx 1 then flush_i in PEND -> FLUSH one cycle with alloc_gnt_o 0; later fill_done_i ignored; valid_o 0000, count_o 0; next grant idx 0.
REQ-038 rst_i asserted mid-PEND between clock edges -> outputs reset immediately; after release, valid_o 0000, busy_o 0, first grant idx 0.
REQ-039 Same-cycle hit_i=1000 and grant on full structure -> grant touch dominates root; assert valid_o/count_o consistency every cycle.
